// File: rtl/hls_deadlock_report_collector.sv
// Deadlock report collector: filters monitor block flags, latches
// confirmed deadlocks and serializes one timestamped report per monitor.
module hls_deadlock_report_collector #(
    parameter int NUM_MON        = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 8,
    localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               deadlock_any,
    output logic [NUM_MON-1:0] confirmed,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [31:0]        report_time
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CONFIRM_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [31:0]        cyc_cnt;
    logic [CNT_W-1:0]   cnt [NUM_MON];
    logic [31:0]        ts  [NUM_MON];
    logic [NUM_MON-1:0] pending;
    logic [NUM_MON-1:0] pending_nx;
    logic [NUM_MON-1:0] confirmed_nx;
    logic [NUM_MON-1:0] hit;
    logic [NUM_MON-1:0] fly;
    logic [IDX_W-1:0]   sel_idx;
    logic [31:0]        sel_time;
    logic               load;
    logic               hs;

    // hit: this cycle completes the run; fly: bit of the report on the wire
    always_comb begin
        hit = '0;
        fly = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            hit[i] = block_in[i] && !confirmed[i] && (cnt[i] == LAST);
            fly[i] = (state == SEND) && (report_idx == IDX_W'(i));
        end
    end

    always_comb begin
        sel_idx  = '0;
        sel_time = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx  = IDX_W'(i);
                sel_time = ts[i];
            end
        end
    end

    assign load = (state == IDLE) && (|pending) && !clear;
    assign hs   = (state == SEND) && report_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SEND;
            SEND:    if (report_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // clear drops everything except the report already in flight
    always_comb begin
        pending_nx   = pending & ~(hs ? fly : '0);
        confirmed_nx = confirmed | hit;
        if (clear) begin
            pending_nx   = pending_nx & fly;
            confirmed_nx = '0;
        end else begin
            pending_nx = pending_nx | hit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            pending      <= '0;
            confirmed    <= '0;
            deadlock_any <= 1'b0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            report_time  <= '0;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt[i] <= '0;
                ts[i]  <= '0;
            end
        end else begin
            state        <= state_nx;
            cyc_cnt      <= cyc_cnt + 32'd1;
            pending      <= pending_nx;
            confirmed    <= confirmed_nx;
            deadlock_any <= |confirmed;
            for (int i = 0; i < NUM_MON; i++) begin
                if (clear || !block_in[i]) begin
                    cnt[i] <= '0;
                end else if (!confirmed[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (hit[i] && !clear) begin
                    ts[i] <= cyc_cnt;
                end
            end
            if (load) begin
                report_valid <= 1'b1;
                report_idx   <= sel_idx;
                report_time  <= sel_time;
            end else if (hs) begin
                report_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// Randomized and directed bench for hls_deadlock_report_collector
// against a cycle-level behavioural model of the report rules.
module tb_hls_deadlock_report_collector;

    localparam int NM = 4;
    localparam int CC = 16;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          report_ready = 1'b1;
    logic [NM-1:0] block_in = '0;
    logic          deadlock_any;
    logic [NM-1:0] confirmed;
    logic          report_valid;
    logic [IW-1:0] report_idx;
    logic [31:0]   report_time;

    hls_deadlock_report_collector #(
        .NUM_MON(NM),
        .CONFIRM_CYCLES(CC),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .block_in(block_in),
        .clear(clear),
        .deadlock_any(deadlock_any),
        .confirmed(confirmed),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_idx(report_idx),
        .report_time(report_time)
    );

    always #5 clock = ~clock;

    // behavioural model: state as seen after each rising edge
    int            run [NM];
    logic [NM-1:0] m_conf = '0;
    logic [NM-1:0] m_pend = '0;
    logic [31:0]   m_ts [NM];
    bit            m_valid = 0;
    bit            m_dany = 0;
    int            m_idx = 0;
    logic [31:0]   m_time = '0;
    logic [31:0]   m_cyc = '0;
    bit            ld_req = 0;
    logic [31:0]   ld_val = '0;

    always @(posedge clock) begin : model
        logic [31:0]   now;
        logic [NM-1:0] hit;
        logic [NM-1:0] old_pend;
        logic [31:0]   old_ts [NM];
        bit            old_valid;
        bit            hs;
        bit            found;
        int            old_idx;
        int            sel;
        if (reset) begin
            m_conf = '0;
            m_pend = '0;
            m_dany = 0;
            m_valid = 0;
            m_idx = 0;
            m_time = '0;
            m_cyc = '0;
            for (int i = 0; i < NM; i++) begin
                run[i] = 0;
                m_ts[i] = '0;
            end
        end else begin
            now = ld_req ? ld_val : m_cyc;
            old_pend = m_pend;
            old_ts = m_ts;
            old_valid = m_valid;
            old_idx = m_idx;
            hs = old_valid && report_ready;
            for (int i = 0; i < NM; i++)
                hit[i] = block_in[i] && !m_conf[i] && (run[i] == CC - 1);
            if (old_valid) begin
                if (hs) m_valid = 0;
            end else if (!clear) begin
                found = 0;
                sel = 0;
                for (int i = NM - 1; i >= 0; i--) begin
                    if (old_pend[i]) begin
                        found = 1;
                        sel = i;
                    end
                end
                if (found) begin
                    m_valid = 1;
                    m_idx = sel;
                    m_time = old_ts[sel];
                end
            end
            m_dany = |m_conf;
            if (hs) m_pend[old_idx] = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (clear) begin
                    if (!(old_valid && old_idx == i)) m_pend[i] = 1'b0;
                    m_conf[i] = 1'b0;
                    run[i] = 0;
                end else begin
                    if (hit[i]) begin
                        m_pend[i] = 1'b1;
                        m_conf[i] = 1'b1;
                        m_ts[i] = now;
                    end
                    run[i] = block_in[i] ? run[i] + 1 : 0;
                end
            end
            m_cyc = now + 32'd1;
        end
    end

    int checks = 0;
    int passes = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic cmp_model();
        chk("confirmed", 32'(confirmed), 32'(m_conf));
        chk("deadlock_any", 32'(deadlock_any), 32'(m_dany));
        chk("report_valid", 32'(report_valid), 32'(m_valid));
        chk("report_idx", 32'(report_idx), 32'(m_idx));
        chk("report_time", report_time, m_time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            if (started) cmp_model();
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
    endtask

    initial begin
        step(1);
        started = 1;
        reset = 1'b0;
        cmp_model();
        chk("rst_valid", 32'(report_valid), 32'd0);
        chk("rst_idx", 32'(report_idx), 32'd0);
        chk("rst_time", report_time, 32'd0);
        chk("rst_any", 32'(deadlock_any), 32'd0);

        // single monitor confirmation, timestamp 25
        step(10);
        block_in = 4'b0100;
        step(16);
        chk("t1_conf", 32'(confirmed), 32'h4);
        chk("t1_any_early", 32'(deadlock_any), 32'd0);
        chk("t1_valid_early", 32'(report_valid), 32'd0);
        step(1);
        chk("t1_any", 32'(deadlock_any), 32'd1);
        chk("t1_valid", 32'(report_valid), 32'd1);
        chk("t1_idx", 32'(report_idx), 32'd2);
        chk("t1_time", report_time, 32'd25);
        step(1);
        chk("t1_one_beat", 32'(report_valid), 32'd0);
        block_in = '0;
        pulse_clear();

        // transient stalls never confirm
        block_in = 4'b0001;
        step(15);
        block_in = '0;
        step(1);
        block_in = 4'b0001;
        step(15);
        block_in = '0;
        step(1);
        chk("t2_conf", 32'(confirmed), 32'd0);
        chk("t2_valid", 32'(report_valid), 32'd0);

        // simultaneous confirmation, backpressure, ascending order
        report_ready = 1'b0;
        block_in = 4'b1010;
        step(17);
        chk("t3_valid", 32'(report_valid), 32'd1);
        chk("t3_idx", 32'(report_idx), 32'd1);
        step(19);
        chk("t3_hold_valid", 32'(report_valid), 32'd1);
        chk("t3_hold_idx", 32'(report_idx), 32'd1);
        chk("t3_conf", 32'(confirmed), 32'ha);
        report_ready = 1'b1;
        step(1);
        chk("t3_bubble", 32'(report_valid), 32'd0);
        step(1);
        chk("t3_second_valid", 32'(report_valid), 32'd1);
        chk("t3_second_idx", 32'(report_idx), 32'd3);
        step(1);
        chk("t3_done", 32'(report_valid), 32'd0);
        block_in = '0;
        pulse_clear();

        // clear during SEND keeps the in-flight report only
        report_ready = 1'b0;
        block_in = 4'b1010;
        step(17);
        chk("t4_valid", 32'(report_valid), 32'd1);
        block_in = '0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_conf", 32'(confirmed), 32'd0);
        chk("t4_inflight", 32'(report_valid), 32'd1);
        chk("t4_inflight_idx", 32'(report_idx), 32'd1);
        step(1);
        chk("t4_any", 32'(deadlock_any), 32'd0);
        report_ready = 1'b1;
        step(1);
        chk("t4_done", 32'(report_valid), 32'd0);
        step(4);
        chk("t4_no_idx3", 32'(report_valid), 32'd0);
        block_in = 4'b1000;
        step(16);
        chk("t4_reconf", 32'(confirmed), 32'h8);
        step(1);
        chk("t4_re_idx", 32'(report_idx), 32'd3);
        chk("t4_re_valid", 32'(report_valid), 32'd1);
        step(1);
        block_in = '0;
        pulse_clear();

        // confirmation coincides with clear
        block_in = 4'b0001;
        step(15);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        block_in = '0;
        chk("t5_conf", 32'(confirmed), 32'd0);
        step(1);
        chk("t5_valid", 32'(report_valid), 32'd0);

        // reset mid-SEND
        report_ready = 1'b0;
        block_in = 4'b0010;
        step(17);
        chk("t6_valid_pre", 32'(report_valid), 32'd1);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_valid", 32'(report_valid), 32'd0);
        chk("t6_idx", 32'(report_idx), 32'd0);
        chk("t6_time", report_time, 32'd0);
        chk("t6_conf", 32'(confirmed), 32'd0);
        step(16);
        chk("t6_reconf", 32'(confirmed), 32'h2);
        step(1);
        chk("t6_rvalid", 32'(report_valid), 32'd1);
        chk("t6_rtime", report_time, 32'd15);
        report_ready = 1'b1;
        step(1);
        block_in = '0;
        pulse_clear();

        // cycle counter wrap
        force dut.cyc_cnt = 32'hFFFF_FFF4;
        ld_val = 32'hFFFF_FFF4;
        ld_req = 1;
        block_in = 4'b0001;
        #1;
        release dut.cyc_cnt;
        step(1);
        ld_req = 0;
        step(15);
        chk("t7_conf", 32'(confirmed), 32'h1);
        step(1);
        chk("t7_valid", 32'(report_valid), 32'd1);
        chk("t7_time", report_time, 32'd3);
        step(1);
        block_in = '0;
        pulse_clear();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NM; i++)
                if ($urandom_range(0, 19) == 0) block_in[i] = ~block_in[i];
            report_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 149) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0;
        clear = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hls_deadlock_report_collector.md
Name: hls_deadlock_report_collector

Overview:
Consumer end of the per-dataflow-region deadlock monitors. It takes the registered block flags from NUM_MON monitors and filters out transient stalls with a persistence counter per monitor. Confirmed deadlocks are latched as sticky status. One report per confirmed monitor (index plus cycle timestamp) is serialized over a valid/ready stream to the debug/trace sink. The block sits at the top level of the HLS-generated wrapper, beside the monitors.

Parameters:
NUM_MON, 4, number of monitor block inputs (1..16).
CONFIRM_CYCLES, 16, consecutive block cycles needed to confirm a deadlock (1..255).
CNT_W, 8, persistence counter width; must hold CONFIRM_CYCLES.
IDX_W (localparam), max(1, clog2(NUM_MON)), report index width.

Ports:
clock  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
block_in  input  NUM_MON  block output of monitor i, level
clear  input  1  single-cycle pulse; clears sticky state and pending reports
deadlock_any  output  1  OR of sticky confirmed flags, registered
confirmed  output  NUM_MON  sticky per-monitor confirmed flags
report_valid  output  1  report stream valid
report_ready  input  1  report stream ready
report_idx  output  IDX_W  index of the reported monitor
report_time  output  32  cycle counter value at confirmation

Behaviour:
- Reset (reset=1 at an edge): all counters, confirmed, pending, timestamps and the FSM clear. deadlock_any=0, report_valid=0, report_idx=0, report_time=0.
- Cycle counter: 32-bit free-running. Value 0 in the first cycle after reset deasserts, +1 every cycle, wraps 0xFFFFFFFF->0 silently.
- Persistence counter per monitor:
  - block_in[i]=0 -> cnt[i]<=0.
  - block_in[i]=1 and confirmed[i]=0 -> cnt[i]<=cnt[i]+1.
  - When block_in[i]=1 and cnt[i]==CONFIRM_CYCLES-1: confirmed[i]<=1, pending[i]<=1, ts[i]<=current cycle counter.
  - Net effect: block held for cycles 0..CONFIRM_CYCLES-1 makes confirmed[i] visible in cycle CONFIRM_CYCLES.
  - Any 0 on block_in[i] before then restarts the count.
  - Counter saturates/holds once confirmed; no reconfirmation until clear.
- deadlock_any is updated combinationally from confirmed then registered, so it is visible one cycle after confirmed.
- Report FSM, states IDLE and SEND:
  - IDLE: if any pending bit is set, select the lowest-indexed pending i. Load report_idx=i and report_time=ts[i]. Assert report_valid. Go to SEND.
  - SEND: hold report_valid, report_idx and report_time stable until report_ready=1. On the handshake, clear pending[i], drop report_valid and return to IDLE.
  - One idle bubble cycle minimum between reports.
  - report_valid is never withdrawn without a handshake, except by reset.
- clear=1:
  - Clears confirmed, all pending bits not currently in flight, and all cnt.
  - In SEND, the in-flight report is kept and completes normally; its pending bit clears on the handshake.
  - A confirmation in the same cycle as clear is discarded: clear wins, and cnt restarts from 0.
- Simultaneous confirmations: all set in the same cycle; reports go out in ascending index order.
- Reset mid-SEND: report_valid=0 on the next cycle and the report is lost.

Test Plan:
1. CONFIRM_CYCLES=16, block_in[2]=1 from cycle 10 (counter=10) onward, report_ready=1:
   - confirmed[2]=1 in cycle 26; deadlock_any=1 in cycle 27.
   - report_valid=1 in cycle 27 with report_idx=2, report_time=25, for exactly one cycle.
2. block_in[0] pulsed high for 15 cycles, low for 1 cycle, high for 15 cycles -> confirmed stays 0 and no report.
3. block_in[3] and block_in[1] rise in the same cycle, report_ready=0 for 20 cycles then 1:
   - report idx=1 is held stable the whole time, then completes.
   - After one bubble cycle, report idx=3 follows.
4. clear asserted during SEND of idx=1 while idx=3 is pending:
   - idx=1 completes; no idx=3 report; confirmed=0, deadlock_any=0.
   - Re-holding block_in[3] for 16 cycles reconfirms it.
5. Confirmation cycle coincides with clear -> confirmed stays 0.
6. Reset asserted mid-SEND -> all outputs 0 next cycle; cycle counter restarts at 0.
7. Force the cycle counter near wrap -> report_time is the wrapped value; no side effects.
